computie_bus_arbiter: RTL
=========================

# computie_bus_arbiter

Bus-mastership arbiter for the Computie bus. Shares the bus between up to `NUM_MASTERS` requesting masters using a 68k-style request / grant / grant-acknowledge handshake with round-robin fairness. It watches `addr_strobe` so that mastership only changes between bus cycles, and it revokes a grant that is never acknowledged. It sits beside `computie_bus_ctrl` on the same backplane signals.

## Interface

Parameters:
- `NUM_MASTERS`, default 4: number of requesters, 2..8.
- `ACK_TIMEOUT`, default 15: cycles a grant may stay unacknowledged before it is revoked, 1..255.
- `OWNER_W`, default `$clog2(NUM_MASTERS)`: width of `owner`.

Ports (clock and reset first):
- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `request_n`  in  NUM_MASTERS  per-master bus request, active low, asynchronous to `clk`.
- `grant_ack_n`  in  1  shared grant acknowledge, active low; the owner holds it low for its whole tenure. Asynchronous.
- `addr_strobe`  in  1  bus address strobe, active low; low means a bus cycle is in progress. Asynchronous.
- `grant_n`  out  NUM_MASTERS  per-master grant, active low, at most one low at a time.
- `owner`  out  OWNER_W  index of the master currently granted or owning the bus.
- `owner_valid`  out  1  high while a master owns the bus (OWNED state).
- `bus_busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked for lack of acknowledge.

## Operation

- **Input synchronisers.** `request_n`, `grant_ack_n` and `addr_strobe` each pass through a 2-flop synchroniser. All decisions below use the synchronised values (`req_s`, `ack_s`, `as_s`).
- **Round-robin pointer.** `last_owner` (OWNER_W bits). Search order is `last_owner+1`, `last_owner+2`, … modulo `NUM_MASTERS`. The first master with `req_s` low is selected.
- **IDLE.**
  - `grant_n` is all ones.
  - If any `req_s` is low, `as_s` is high and `ack_s` is high: latch `sel`, drive `owner<=sel`, drive `grant_n[sel]<=0`, clear the timer, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT.** Conditions are checked in priority order:
  1. `ack_s` low: `grant_n` goes all ones, `last_owner<=sel`, go to OWNED.
  2. `req_s[sel]` high (request withdrawn): `grant_n` goes all ones, go to IDLE. `last_owner` is unchanged.
  3. Timer equals `ACK_TIMEOUT-1`: `grant_n` goes all ones, `timeout_err<=1` for one cycle, `last_owner<=sel` (the offender is skipped next), go to IDLE.
  4. Otherwise increment the timer.
- **OWNED.**
  - `owner_valid=1`.
  - Requests from other masters are ignored; there is no preemption.
  - When `ack_s` goes high, go to RELEASE.
- **RELEASE.**
  - Wait until `as_s` is high, so the owner's final bus cycle has finished.
  - Then go to IDLE. This gives a minimum of one turnaround cycle.
- **Timer.** 8 bits, saturating; it is compared only in GRANT.
- **`NUM_MASTERS` not a power of two.** The pointer wraps at `NUM_MASTERS-1` to 0, never to an unused index.
- **Illegal state encoding.** Recovers to IDLE with `grant_n` all ones.

## Timing

- **Registers.** All outputs are registered; there is no combinational path from input to output.
- **Reset values** (asynchronous, immediate on `reset_n` low):
  - state = IDLE, `grant_n` = all ones, `owner` = 0, `owner_valid` = 0, `bus_busy` = 0, `timeout_err` = 0.
  - `last_owner` = `NUM_MASTERS-1`, so master 0 has first priority.
  - Synchronisers reset to 1 (inactive).
- **Grant latency.** `request_n` low with setup before edge 0: the synchronised value is valid after edge 1, and `grant_n` goes low after edge 2. Latency is 2 cycles from an idle bus.
- **Acknowledge latency.** `grant_ack_n` low before edge n: the arbiter enters OWNED and `grant_n` goes high after edge n+2.
- **Release-to-next-grant.** `ack` high before edge m, with the bus idle: RELEASE after edge m+2, IDLE after edge m+3, next `grant_n` low after edge m+4.
- **Timeout.** `grant_n` stays low for exactly `ACK_TIMEOUT` cycles. `timeout_err` pulses in the cycle `grant_n` returns high.
- **Simultaneous events in GRANT.** Acknowledge beats withdrawal beats timeout.
- **Reset mid-tenure.** `grant_n` releases immediately. After reset, an `ack` still held low blocks new grants until it is released.

## Test plan

- **Reset:** assert `reset_n` low mid-OWNED → `grant_n`=4'b1111, `bus_busy`=0 and `owner_valid`=0 with no clock edge; after release, a request from master 2 → `grant_n`=4'b1011 two cycles after synchronisation.
- **Simultaneous requests:** all four `request_n` low and held, each master acks and releases in turn → grants in order 0,1,2,3,0; `owner` matches each grant; `owner_valid` high only between ack and release.
- **Cycle in progress:** `addr_strobe` low while master 1 requests → no grant until `addr_strobe` high; `grant_n[1]` low 2 cycles after synchronised `addr_strobe` high.
- **No acknowledge:** with `ACK_TIMEOUT`=15, master 3 requests and never acks → `grant_n[3]` low for exactly 15 cycles, one-cycle `timeout_err`, then IDLE; master 3 rotated to lowest priority.
- **Withdrawal:** master 0 requests, then raises `request_n` before ack → `grant_n` all ones, `last_owner` unchanged, no `timeout_err`, and master 0 is first again on re-request.
- **Release while strobe active:** owner drops `ack` while `addr_strobe` is still low → arbiter holds RELEASE, `bus_busy`=1, and the next grant issues only after `addr_strobe` rises.

Source files
------------

// File: rtl/computie_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : computie_bus_arbiter
// Purpose  : Round-robin bus-mastership arbiter with a 68k-style
//            request / grant / grant-acknowledge handshake.
// Revision : 1.0
// ============================================================================
module computie_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ACK_TIMEOUT = 15,
    parameter int OWNER_W     = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_MASTERS-1:0] request_n,
    input  logic                   grant_ack_n,
    input  logic                   addr_strobe,
    output logic [NUM_MASTERS-1:0] grant_n,
    output logic [OWNER_W-1:0]     owner,
    output logic                   owner_valid,
    output logic                   bus_busy,
    output logic                   timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_OWNED   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0]             c_timer_last = 8'(ACK_TIMEOUT - 1);
    localparam logic [NUM_MASTERS-1:0] c_no_grant   = '1;

    logic [NUM_MASTERS-1:0] r_req_meta, r_req_s;
    logic                   r_ack_meta, r_ack_s;
    logic                   r_as_meta,  r_as_s;

    state_t                 r_state, w_state_next;
    logic [NUM_MASTERS-1:0] r_grant_n, w_grant_n_next;
    logic [OWNER_W-1:0]     r_owner, w_owner_next;
    logic [OWNER_W-1:0]     r_last_owner, w_last_owner_next;
    logic [7:0]             r_timer, w_timer_next;
    logic                   r_owner_valid, r_bus_busy, r_timeout_err;
    logic                   w_timeout_next;

    logic [OWNER_W-1:0]     w_sel;
    logic                   w_any_req;

    function automatic logic [OWNER_W-1:0] rr_index(input logic [OWNER_W-1:0] base,
                                                    input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_MASTERS) begin
            sum = sum - NUM_MASTERS;
        end
        return OWNER_W'(sum);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_meta <= '1;
            r_req_s    <= '1;
            r_ack_meta <= 1'b1;
            r_ack_s    <= 1'b1;
            r_as_meta  <= 1'b1;
            r_as_s     <= 1'b1;
        end else begin
            r_req_meta <= request_n;
            r_req_s    <= r_req_meta;
            r_ack_meta <= grant_ack_n;
            r_ack_s    <= r_ack_meta;
            r_as_meta  <= addr_strobe;
            r_as_s     <= r_as_meta;
        end
    end

    // Scan from farthest to nearest offset so the nearest requester wins.
    always_comb begin
        w_sel     = '0;
        w_any_req = 1'b0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (!r_req_s[rr_index(r_last_owner, i)]) begin
                w_sel     = rr_index(r_last_owner, i);
                w_any_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_grant_n_next    = r_grant_n;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_timer_next      = r_timer;
        w_timeout_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_grant_n_next = c_no_grant;
                if (w_any_req && r_as_s && r_ack_s) begin
                    w_owner_next   = w_sel;
                    w_grant_n_next = ~(NUM_MASTERS'(1) << w_sel);
                    w_timer_next   = 8'd0;
                    w_state_next   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Acknowledge beats withdrawal beats timeout.
                if (!r_ack_s) begin
                    w_grant_n_next    = c_no_grant;
                    w_last_owner_next = r_owner;
                    w_state_next      = ST_OWNED;
                end else if (r_req_s[r_owner]) begin
                    w_grant_n_next = c_no_grant;
                    w_state_next   = ST_IDLE;
                end else if (r_timer == c_timer_last) begin
                    w_grant_n_next    = c_no_grant;
                    w_timeout_next    = 1'b1;
                    w_last_owner_next = r_owner;
                    w_state_next      = ST_IDLE;
                end else if (r_timer != 8'hFF) begin
                    w_timer_next = r_timer + 8'd1;
                end
            end
            ST_OWNED: begin
                w_grant_n_next = c_no_grant;
                if (r_ack_s) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_grant_n_next = c_no_grant;
                if (r_as_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_grant_n_next = c_no_grant;
                w_state_next   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_grant_n     <= c_no_grant;
            r_owner       <= '0;
            r_last_owner  <= OWNER_W'(NUM_MASTERS - 1);
            r_timer       <= 8'd0;
            r_owner_valid <= 1'b0;
            r_bus_busy    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_grant_n     <= w_grant_n_next;
            r_owner       <= w_owner_next;
            r_last_owner  <= w_last_owner_next;
            r_timer       <= w_timer_next;
            r_owner_valid <= (w_state_next == ST_OWNED);
            r_bus_busy    <= (w_state_next != ST_IDLE);
            r_timeout_err <= w_timeout_next;
        end
    end

    assign grant_n     = r_grant_n;
    assign owner       = r_owner;
    assign owner_valid = r_owner_valid;
    assign bus_busy    = r_bus_busy;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire
